// File: rtl/tick_recover.sv
// Brings a slow free-running square wave into the clk_in domain as a one-cycle tick enable,
// measures its period and flags a stalled source. Define TICK_RECOVER_FALL_EN for tick_fall/high_time.
module tick_recover #(
  parameter int W       = 22,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 4194303
) (
  input  logic         clk_in,
  input  logic         rstn,
  input  logic         slow_in,
  output logic         level,
  output logic         tick,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         stalled
`ifdef TICK_RECOVER_FALL_EN
  ,
  output logic         tick_fall,
  output logic [W-1:0] high_time
`endif
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED, STALLED} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TO      = W'(TIMEOUT);

  logic [SYNC-1:0] sync_pipe;
  logic [SYNC-1:0] vld_pipe;
  logic            prev;
  logic            armed;
  logic            rise;
  logic            timeout;
  logic [W-1:0]    cnt;
  state_t          state, state_nxt;

  assign level   = sync_pipe[SYNC-1];
  assign rise    = armed & level & ~prev;
  assign timeout = (cnt >= TO);

  // vld_pipe marks when level carries a real sample rather than the reset zero,
  // so an input already high at reset release is never mistaken for a rising edge.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      sync_pipe <= '0;
      vld_pipe  <= '0;
      prev      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC-2:0], slow_in};
      vld_pipe  <= {vld_pipe[SYNC-2:0], 1'b1};
      prev      <= level;
      if (vld_pipe[SYNC-1] && !level) armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (rise) state_nxt = MEASURE;
      MEASURE: if (rise) state_nxt = LOCKED;
               else if (timeout) state_nxt = STALLED;
      LOCKED:  if (!rise && timeout) state_nxt = STALLED;
      STALLED: if (rise) state_nxt = MEASURE;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state  <= SEARCH;
      cnt    <= '0;
      tick   <= 1'b0;
      period <= '0;
    end else begin
      state <= state_nxt;
      tick  <= rise;
      if (rise) cnt <= W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      // A gap that spans a stall is never published as a period.
      if (rise && (state == MEASURE || state == LOCKED)) period <= cnt;
    end
  end

  assign period_valid = (state == LOCKED);
  assign stalled      = (state == STALLED);

`ifdef TICK_RECOVER_FALL_EN
  logic fall;
  assign fall = ~level & prev;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      tick_fall <= 1'b0;
      high_time <= '0;
    end else begin
      tick_fall <= fall;
      if (fall && state != SEARCH) high_time <= cnt;
    end
  end
`endif
endmodule

// File: tb/tb_tick_recover.sv
// Directed bench for tick_recover: two instances (TIMEOUT=50/W=22 and TIMEOUT=15/W=4) checked
// every cycle against an edge-time model, plus literal expectations at key points.
module tb_tick_recover;
  localparam int SY = 2;

  logic clk_in;
  logic rstn;
  logic slow_a, slow_b;
  logic lvl_a, tick_a, pv_a, st_a;
  logic lvl_b, tick_b, pv_b, st_b;
  logic [21:0] per_a;
  logic [3:0]  per_b;
`ifdef TICK_RECOVER_FALL_EN
  logic tf_a, tf_b;
  logic [21:0] ht_a;
  logic [3:0]  ht_b;
`endif

  int checks = 0;
  int errors = 0;

  tick_recover #(.W(22), .SYNC(SY), .TIMEOUT(50)) ua (
    .clk_in(clk_in), .rstn(rstn), .slow_in(slow_a), .level(lvl_a), .tick(tick_a),
    .period(per_a), .period_valid(pv_a), .stalled(st_a)
`ifdef TICK_RECOVER_FALL_EN
    , .tick_fall(tf_a), .high_time(ht_a)
`endif
  );

  tick_recover #(.W(4), .SYNC(SY), .TIMEOUT(15)) ub (
    .clk_in(clk_in), .rstn(rstn), .slow_in(slow_b), .level(lvl_b), .tick(tick_b),
    .period(per_b), .period_valid(pv_b), .stalled(st_b)
`ifdef TICK_RECOVER_FALL_EN
    , .tick_fall(tf_b), .high_time(ht_b)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Model: edges are timestamped by clk_in edge number; mode 0 search, 1 measure, 2 locked, 3 stalled.
  int to_v[2]  = '{50, 15};
  int max_v[2] = '{4194303, 15};
  int cyc = 0;
  int mode[2], last[2], rise_at[2], fall_at[2], nsamp[2], m_period[2], m_high[2];
  int nticks[2] = '{0, 0};
  int stall_gap[2] = '{0, 0};
  logic [3:0] hist[2];
  logic m_tick[2], m_tfall[2];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic mreset(input int i);
    mode[i] = 0; last[i] = 0; rise_at[i] = -1; fall_at[i] = -1; nsamp[i] = 0;
    m_period[i] = 0; m_high[i] = 0; hist[i] = '0; m_tick[i] = 1'b0; m_tfall[i] = 1'b0;
  endtask

  task automatic mstep(input int i, input logic s);
    m_tick[i]  = (rise_at[i] == cyc);
    m_tfall[i] = (fall_at[i] == cyc);
    if (m_tick[i]) begin
      if (mode[i] == 1 || mode[i] == 2) m_period[i] = sat(cyc - last[i], max_v[i]);
      mode[i] = (mode[i] == 1 || mode[i] == 2) ? 2 : 1;
      last[i] = cyc;
      nticks[i]++;
    end else if ((mode[i] == 1 || mode[i] == 2) && (cyc - last[i] >= to_v[i])) begin
      mode[i] = 3;
      stall_gap[i] = cyc - last[i];
    end
    if (m_tfall[i] && mode[i] != 0) m_high[i] = sat(cyc - last[i], max_v[i]);
    // an edge needs two real samples; it surfaces SYNC edges after being sampled
    if (nsamp[i] >= 1 && hist[i][0] != s) begin
      if (s) rise_at[i] = cyc + SY;
      else   fall_at[i] = cyc + SY;
    end
    hist[i] = {hist[i][2:0], s};
    nsamp[i]++;
  endtask

  initial begin
    mreset(0); mreset(1);
    forever begin
      @(posedge clk_in or negedge rstn);
      if (!rstn) begin
        mreset(0); mreset(1);
      end else begin
        cyc++;
        mstep(0, slow_a);
        mstep(1, slow_b);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_core(input int i, input int lvl, input int tk, input int per,
                          input int pv, input int st);
    chk($sformatf("level[%0d]", i), lvl, int'(hist[i][SY-1]));
    chk($sformatf("tick[%0d]", i), tk, int'(m_tick[i]));
    chk($sformatf("period[%0d]", i), per, m_period[i]);
    chk($sformatf("period_valid[%0d]", i), pv, int'(mode[i] == 2));
    chk($sformatf("stalled[%0d]", i), st, int'(mode[i] == 3));
  endtask

  initial forever begin
    @(negedge clk_in);
    cmp_core(0, int'(lvl_a), int'(tick_a), int'(per_a), int'(pv_a), int'(st_a));
    cmp_core(1, int'(lvl_b), int'(tick_b), int'(per_b), int'(pv_b), int'(st_b));
`ifdef TICK_RECOVER_FALL_EN
    chk("tick_fall[0]", int'(tf_a), int'(m_tfall[0]));
    chk("high_time[0]", int'(ht_a), m_high[0]);
    chk("tick_fall[1]", int'(tf_b), int'(m_tfall[1]));
    chk("high_time[1]", int'(ht_b), m_high[1]);
`endif
  end

  task automatic drive(input int i, input logic v, input int n);
    repeat (n) begin
      @(negedge clk_in);
      if (i == 0) slow_a = v;
      else        slow_b = v;
    end
  endtask

  task automatic wave(input int i, input int hi, input int lo, input int reps);
    repeat (reps) begin
      drive(i, 1'b1, hi);
      drive(i, 1'b0, lo);
    end
  endtask

  initial begin
    rstn = 1'b0; slow_a = 1'b0; slow_b = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tick", int'(tick_a), 0);
    chk("rst_period", int'(per_a), 0);
    chk("rst_valid", int'(pv_a), 0);
    chk("rst_stalled", int'(st_a), 0);
    chk("rst_level_b", int'(lvl_b), 0);
    @(posedge clk_in); #2 rstn = 1'b1;

    // B: high through reset release gives no tick until a real low-to-high
    drive(1, 1'b1, 10);
    chk("hi_at_release_level", int'(lvl_b), 1);
    chk("hi_at_release_nticks", nticks[1], 0);
    drive(1, 1'b0, 3);
    drive(1, 1'b1, 10);
    chk("first_edge_nticks", nticks[1], 1);
    chk("first_edge_valid", int'(pv_b), 0);
    chk("first_edge_stalled", int'(st_b), 0);

    // B: period 20 exceeds TIMEOUT 15, never locks
    drive(1, 1'b0, 10);
    wave(1, 10, 10, 4);
    chk("w4_stalled", int'(st_b), 1);
    chk("w4_valid", int'(pv_b), 0);
    chk("w4_period", int'(per_b), 0);
    chk("w4_nticks", nticks[1], 5);

    // A: latency of two sync stages, then 5/5 square wave
    @(negedge clk_in); slow_a = 1'b1;
    @(posedge clk_in); #1 chk("lat_k", int'(tick_a), 0);
    @(posedge clk_in); #1 chk("lat_k1", int'(tick_a), 0);
    @(posedge clk_in); #1 chk("lat_k2", int'(tick_a), 1);
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 5);
    wave(0, 5, 5, 6);
    chk("lock_period", int'(per_a), 10);
    chk("lock_valid", int'(pv_a), 1);
    chk("model_period", m_period[0], 10);

    // A: stall after 50 quiet cycles, period retained
    drive(0, 1'b0, 60);
    chk("stall_flag", int'(st_a), 1);
    chk("stall_valid", int'(pv_a), 0);
    chk("stall_period", int'(per_a), 10);
    chk("model_stall_gap", stall_gap[0], 50);
    wave(0, 5, 5, 1);
    chk("resume_stalled", int'(st_a), 0);
    chk("resume_valid", int'(pv_a), 0);
    wave(0, 5, 5, 2);
    chk("relock_valid", int'(pv_a), 1);
    chk("relock_period", int'(per_a), 10);

    // asynchronous reset pulse while locked
    @(posedge clk_in); #2 rstn = 1'b0;
    #1;
    chk("async_valid", int'(pv_a), 0);
    chk("async_period", int'(per_a), 0);
    chk("async_tick", int'(tick_a), 0);
    chk("async_stalled_b", int'(st_b), 0);
    @(posedge clk_in); #2 rstn = 1'b1;
    drive(0, 1'b0, 4);
    wave(0, 5, 5, 1);
    chk("post_rst_valid", int'(pv_a), 0);
    chk("post_rst_period", int'(per_a), 0);

    // 6-high/4-low wave
    wave(0, 6, 4, 4);
    chk("w64_period", int'(per_a), 10);
    chk("w64_valid", int'(pv_a), 1);
`ifdef TICK_RECOVER_FALL_EN
    chk("w64_high_time", int'(ht_a), 6);
    chk("model_high_time", m_high[0], 6);
`endif
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
